// File: rtl/shift_add_multiplier_16.sv
// Sequential 16x16 unsigned shift-and-add multiplier with valid/ready handshakes.
// One partial product is accumulated per RUN cycle through a 32-bit carry-lookahead adder.

module cla_adder_32 (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  // gc[k] is the carry entering 4-bit group k; groups chain via group generate/propagate
  logic [8:0] gc;

  assign gc[0] = cin;

  for (genvar gi = 0; gi < 8; gi++) begin : g_grp
    logic [3:0] gg;
    logic [3:0] pp;
    logic [3:0] cc;
    logic       grp_g;
    logic       grp_p;

    assign gg = x[4*gi +: 4] & y[4*gi +: 4];
    assign pp = x[4*gi +: 4] ^ y[4*gi +: 4];

    assign cc[0] = gc[gi];
    assign cc[1] = gg[0] | (pp[0] & cc[0]);
    assign cc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & cc[0]);
    assign cc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                 | (pp[2] & pp[1] & pp[0] & cc[0]);

    assign grp_g = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                 | (pp[3] & pp[2] & pp[1] & gg[0]);
    assign grp_p = &pp;

    assign gc[gi+1]       = grp_g | (grp_p & gc[gi]);
    assign sum[4*gi +: 4] = pp ^ cc;
  end

  assign cout = gc[8];

endmodule

module shift_add_multiplier_16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] product,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] acc_reg, acc_next;
  logic [31:0] mcand_reg, mcand_next;
  logic [15:0] mplr_reg, mplr_next;
  logic [3:0]  count_reg, count_next;
  logic [31:0] sum;
  logic        cout;

  cla_adder_32 u_adder (
    .x    (acc_reg),
    .y    (mcand_reg),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  assign in_ready  = (state_reg == IDLE) && !rst;
  assign busy      = (state_reg == RUN);
  assign out_valid = (state_reg == DONE);
  assign product   = acc_reg;

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    mcand_next = mcand_reg;
    mplr_next  = mplr_reg;
    count_next = count_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_next = RUN;
          mcand_next = {16'h0000, a};
          mplr_next  = b;
          acc_next   = 32'h0;
          count_next = 4'd0;
        end
      end
      RUN: begin
        if (mplr_reg[0]) begin
          acc_next = sum;
        end
        mcand_next = mcand_reg << 1;
        mplr_next  = mplr_reg >> 1;
        // Hold at 15 on the final step so the counter never wraps mid-operation
        if (count_reg == 4'd15) begin
          state_next = DONE;
        end else begin
          count_next = count_reg + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      acc_reg   <= 32'h0;
      mcand_reg <= 32'h0;
      mplr_reg  <= 16'h0;
      count_reg <= 4'd0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      mcand_reg <= mcand_next;
      mplr_reg  <= mplr_next;
      count_reg <= count_next;
    end
  end

  // A 16x16 product always fits in 32 bits, so the accumulate never carries out
  always_ff @(posedge clk) begin
    if (!rst && state_reg == RUN) begin
      assert (cout == 1'b0);
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier_16.sv
// Self-checking bench for shift_add_multiplier_16: directed cases plus a randomized
// stream checked against a plain-arithmetic scoreboard.

module tb_shift_add_multiplier_16;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  shift_add_multiplier_16 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
    logic [31:0] xe;
    logic [31:0] ye;
    xe = {16'h0000, x};
    ye = {16'h0000, y};
    return xe * ye;
  endfunction

  function automatic logic [15:0] pick_operand();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return 16'h0000;
    if (r == 1) return 16'hFFFF;
    return 16'($urandom);
  endfunction

  // One complete operation: accept, count latency and busy cycles, stall in DONE, release
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input int stall,
                       input int inject);
    int cycles;
    int busy_cnt;
    logic [31:0] held;
    @(negedge clk);
    check("in_ready_idle", {31'b0, in_ready}, 32'd1);
    a         = ta;
    b         = tb;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    cycles   = 1;
    busy_cnt = 0;
    while (!out_valid && cycles < 100) begin
      if (cycles == 1) check("in_ready_run", {31'b0, in_ready}, 32'd0);
      if (busy) busy_cnt++;
      if (inject != 0 && cycles == inject) begin
        in_valid = 1'b1;
        a        = 16'd9;
        b        = 16'd9;
      end else begin
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
      end
      @(negedge clk);
      cycles++;
    end
    in_valid = 1'b0;
    check("latency", cycles, 32'd17);
    check("busy_cycles", busy_cnt, 32'd16);
    check("product", product, ref_mul(ta, tb));
    held = product;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_valid", {31'b0, out_valid}, 32'd1);
      check("stall_hold", product, held);
      check("stall_in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("in_ready_after", {31'b0, in_ready}, 32'd1);
    check("out_valid_after", {31'b0, out_valid}, 32'd0);
    $display("op a=0x%04h b=0x%04h product=0x%08h latency=%0d", ta, tb, held, cycles);
  endtask

  initial begin
    int spurious;
    int accepted;
    int delivered;
    int cycles;
    logic [31:0] exp_q[$];

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 16'h0;
    b         = 16'h0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_product", product, 32'd0);
    rst = 1'b0;
    #1;
    check("in_ready_post_rst", {31'b0, in_ready}, 32'd1);

    do_op(16'd3, 16'd5, 0, 0);
    do_op(16'hFFFF, 16'hFFFF, 0, 0);
    do_op(16'h0000, 16'h1234, 0, 0);
    do_op(16'h1234, 16'h0000, 0, 0);
    do_op(16'h00FF, 16'h0101, 5, 0);
    do_op(16'd7, 16'd6, 0, 5);

    // Abort an operation part-way through RUN
    @(negedge clk);
    a        = 16'h1111;
    b        = 16'h2222;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("abort_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_in_ready_rst", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_busy_after", {31'b0, busy}, 32'd0);
    check("abort_valid_after", {31'b0, out_valid}, 32'd0);
    check("abort_product", product, 32'd0);
    check("abort_in_ready", {31'b0, in_ready}, 32'd1);
    spurious = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) spurious++;
    end
    check("abort_no_output", spurious, 32'd0);
    do_op(16'd7, 16'd6, 0, 0);

    // Random stream: inputs driven at negedge; handshakes resolve at the following posedge
    accepted  = 0;
    delivered = 0;
    cycles    = 0;
    while ((accepted < 1000 || exp_q.size() != 0) && cycles < 60000) begin
      @(negedge clk);
      cycles++;
      in_valid  = (accepted < 1000) && ($urandom_range(0, 3) != 0);
      a         = pick_operand();
      b         = pick_operand();
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rand_spurious", 32'd1, 32'd0);
        end else begin
          check("rand_product", product, exp_q[0]);
          $display("rand #%0d product=0x%08h expected=0x%08h", delivered, product, exp_q[0]);
          void'(exp_q.pop_front());
          delivered++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_mul(a, b));
        accepted++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("rand_accepted", accepted, 32'd1000);
    check("rand_delivered", delivered, 32'd1000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
